// File: rtl/vc_route_unit_pkg.sv
// rtl/vc_route_unit_pkg.sv - shared network types and constants for the VC routing stage
package vc_route_unit_pkg;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_t;

  localparam int PORT_NUM_W = 3;
  localparam int PORT_NUM   = 5;

  typedef enum logic [PORT_NUM_W-1:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    NORTH = 3'd2,
    WEST  = 3'd3,
    SOUTH = 3'd4
  } port_t;

  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_t;

  // Field widths never drop below one bit, even for a single-node dimension.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_route_unit_if.sv
// rtl/vc_route_unit_if.sv - flit input and routed-flit output handshake bundle
interface vc_route_unit_if #(
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int VW = 1
);
  import vc_route_unit_pkg::*;

  logic          flit_valid_in;
  flit_type_t    flit_type_in;
  logic [VW-1:0] flit_vc_in;
  logic [XW-1:0] dest_x_in;
  logic [YW-1:0] dest_y_in;
  logic          flit_ready_out;

  logic          route_valid_out;
  port_t         route_port_out;
  logic [VW-1:0] route_vc_out;
  flit_type_t    route_type_out;
  logic          route_ready_in;

  modport master (
    output flit_valid_in, flit_type_in, flit_vc_in, dest_x_in, dest_y_in, route_ready_in,
    input  flit_ready_out, route_valid_out, route_port_out, route_vc_out, route_type_out
  );

  modport slave (
    input  flit_valid_in, flit_type_in, flit_vc_in, dest_x_in, dest_y_in, route_ready_in,
    output flit_ready_out, route_valid_out, route_port_out, route_vc_out, route_type_out
  );

endinterface

// File: rtl/vc_route_unit_route_compute.sv
// rtl/vc_route_unit_route_compute.sv - combinational XY/YX next-port and address check
module route_compute
  import vc_route_unit_pkg::*;
#(
  parameter int MY_X_ADDR  = 0,
  parameter int MY_Y_ADDR  = 0,
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int ROUTE_MODE = 0,
  parameter int XW         = 2,
  parameter int YW         = 2
) (
  input  logic [XW-1:0] dest_x_i,
  input  logic [YW-1:0] dest_y_i,
  output port_t         port_o,
  output logic          addr_err_o
);

  localparam int DW = ((XW > YW) ? XW : YW) + 1;

  logic signed [DW-1:0] dx, dy;
  port_t x_dir, y_dir;

  always_comb begin
    dx = $signed(DW'(dest_x_i)) - $signed(DW'(MY_X_ADDR));
    dy = $signed(DW'(dest_y_i)) - $signed(DW'(MY_Y_ADDR));
    addr_err_o = (32'(dest_x_i) >= 32'(X_NODES)) || (32'(dest_y_i) >= 32'(Y_NODES));

    // Sign bit and zero test avoid mixed-signedness compares against literals.
    x_dir = LOCAL;
    if (dx[DW-1])        x_dir = WEST;
    else if (dx != '0)   x_dir = EAST;
    y_dir = LOCAL;
    if (dy[DW-1])        y_dir = NORTH;
    else if (dy != '0)   y_dir = SOUTH;

    if (ROUTE_MODE == ROUTE_YX) port_o = (y_dir != LOCAL) ? y_dir : x_dir;
    else                        port_o = (x_dir != LOCAL) ? x_dir : y_dir;
    if (addr_err_o) port_o = LOCAL;
  end

endmodule

// File: rtl/vc_route_unit.sv
// rtl/vc_route_unit.sv - per-VC route stage: head-flit port latch, registered valid/ready output
// Optional per-port transfer counters are built when VC_ROUTE_STATS_EN is defined.
module vc_route_unit
  import vc_route_unit_pkg::*;
#(
  parameter int MY_X_ADDR  = 0,
  parameter int MY_Y_ADDR  = 0,
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int VC_NUM     = 2,
  parameter int ROUTE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  vc_route_unit_if.slave    rt,
  output logic [VC_NUM-1:0] error_out
`ifdef VC_ROUTE_STATS_EN
  ,
  input  port_t             stats_sel,
  input  logic              stats_clear,
  output logic [15:0]       stats_count_out
`endif
);

  localparam int XW = clog2_min1(X_NODES);
  localparam int YW = clog2_min1(Y_NODES);
  localparam int VW = clog2_min1(VC_NUM);

  logic          flit_ready, accept, is_head, addr_err;
  port_t         calc_port, emit_port, cur_latch;
  vc_state_t     cur_state;

  vc_state_t     vc_state_q [VC_NUM];
  vc_state_t     vc_state_d [VC_NUM];
  port_t         latch_q [VC_NUM];
  port_t         latch_d [VC_NUM];
  logic [VC_NUM-1:0] error_q, error_d;

  logic          valid_q, valid_d;
  port_t         port_q, port_d;
  logic [VW-1:0] vc_q, vc_d;
  flit_type_t    type_q, type_d;

  route_compute #(
    .MY_X_ADDR (MY_X_ADDR),
    .MY_Y_ADDR (MY_Y_ADDR),
    .X_NODES   (X_NODES),
    .Y_NODES   (Y_NODES),
    .ROUTE_MODE(ROUTE_MODE),
    .XW        (XW),
    .YW        (YW)
  ) u_route_compute (
    .dest_x_i  (rt.dest_x_in),
    .dest_y_i  (rt.dest_y_in),
    .port_o    (calc_port),
    .addr_err_o(addr_err)
  );

  assign flit_ready = !valid_q || rt.route_ready_in;
  assign accept     = rt.flit_valid_in && flit_ready;
  assign is_head    = (rt.flit_type_in == HEADER) || (rt.flit_type_in == HT);

  always_comb begin
    cur_state = VC_IDLE;
    cur_latch = LOCAL;
    for (int v = 0; v < VC_NUM; v++) begin
      if (rt.flit_vc_in == VW'(v)) begin
        cur_state = vc_state_q[v];
        cur_latch = latch_q[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) begin
        vc_state_q[v] <= VC_IDLE;
        latch_q[v]    <= LOCAL;
      end
      error_q <= '0;
      valid_q <= 1'b0;
      port_q  <= LOCAL;
      vc_q    <= '0;
      type_q  <= HEADER;
    end else begin
      vc_state_q <= vc_state_d;
      latch_q    <= latch_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
      port_q     <= port_d;
      vc_q       <= vc_d;
      type_q     <= type_d;
    end
  end

  // A head flit on an already active VC is a protocol error but still restarts the packet.
  always_comb begin
    vc_state_d = vc_state_q;
    latch_d    = latch_q;
    error_d    = error_q;
    for (int v = 0; v < VC_NUM; v++) begin
      if (accept && (rt.flit_vc_in == VW'(v))) begin
        unique case (rt.flit_type_in)
          HEADER: begin
            latch_d[v]    = calc_port;
            vc_state_d[v] = VC_ACTIVE;
            error_d[v]    = error_q[v] | addr_err | (vc_state_q[v] == VC_ACTIVE);
          end
          HT: begin
            if (vc_state_q[v] == VC_ACTIVE) latch_d[v] = calc_port;
            vc_state_d[v] = VC_IDLE;
            error_d[v]    = error_q[v] | addr_err | (vc_state_q[v] == VC_ACTIVE);
          end
          BODY: error_d[v] = error_q[v] | (vc_state_q[v] == VC_IDLE);
          TAIL: begin
            vc_state_d[v] = VC_IDLE;
            error_d[v]    = error_q[v] | (vc_state_q[v] == VC_IDLE);
          end
        endcase
      end
    end
  end

  always_comb begin
    emit_port = is_head ? calc_port : ((cur_state == VC_ACTIVE) ? cur_latch : LOCAL);
    valid_d   = valid_q;
    port_d    = port_q;
    vc_d      = vc_q;
    type_d    = type_q;
    if (accept) begin
      valid_d = 1'b1;
      port_d  = emit_port;
      vc_d    = rt.flit_vc_in;
      type_d  = rt.flit_type_in;
    end else if (rt.route_ready_in) begin
      valid_d = 1'b0;
    end
  end

  assign rt.flit_ready_out  = flit_ready;
  assign rt.route_valid_out = valid_q;
  assign rt.route_port_out  = port_q;
  assign rt.route_vc_out    = vc_q;
  assign rt.route_type_out  = type_q;
  assign error_out          = error_q;

`ifdef VC_ROUTE_STATS_EN
  logic [15:0] cnt_q [PORT_NUM];

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      for (int p = 0; p < PORT_NUM; p++) cnt_q[p] <= '0;
    end else if (valid_q && rt.route_ready_in) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if ((port_q == PORT_NUM_W'(p)) && (cnt_q[p] != 16'hFFFF)) cnt_q[p] <= cnt_q[p] + 16'd1;
      end
    end
  end

  always_comb begin
    stats_count_out = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (stats_sel == PORT_NUM_W'(p)) stats_count_out = cnt_q[p];
    end
  end
`endif

endmodule
